// File: rtl/poly_addsub_ctrl_if.sv
// poly_addsub_ctrl_if
//   Bundles the job handshake and the coefficient-memory bus of the
//   polynomial add/sub sequencer.
//   master : job requester / memory side (drives start, sub, read data)
//   slave  : the sequencer (drives status, read strobe/address, write port)
//   Signals: start, sub, busy, done, rd_en, rd_addr, rd_data_a, rd_data_b,
//            wr_en, wr_addr, wr_data
interface poly_addsub_ctrl_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              sub;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (
        output start, sub, rd_data_a, rd_data_b,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, sub, rd_data_a, rd_data_b,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/poly_addsub_ctrl.sv
// poly_addsub_ctrl
//   Streams N coefficient pairs from two synchronous-read memories through a
//   modular adder and writes (a + b) mod Q or (a - b) mod Q to a result port,
//   one coefficient per cycle, three pipeline stages, no stalls.
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - synchronous active-low reset
//     bus    - poly_addsub_ctrl_if.slave: start/sub request, busy/done status,
//              shared read strobe/address for memories A and B, read data,
//              result write strobe/address/data

// mod_add: y = (a + b) mod Q for a, b in [0, Q), using a WIDTH+1-bit sum.
module mod_add #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned Q     = 8380417
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

    logic [WIDTH:0] s;

    always_comb begin
        s = {1'b0, a} + {1'b0, b};
        y = (s >= QX) ? WIDTH'(s - QX) : s[WIDTH-1:0];
    end
endmodule

module poly_addsub_ctrl #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned Q      = 8380417,
    parameter int unsigned N      = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    poly_addsub_ctrl_if.slave bus
);
    localparam logic [WIDTH-1:0]  QW   = WIDTH'(Q);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic              accept;
    logic              sub_q;
    logic [ADDR_W-1:0] rd_addr_q;

    // stage 1: valid + address of the read whose data is on rd_data_*
    logic              v1;
    logic [ADDR_W-1:0] addr1;

    // stage 2: registered write port
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;

    logic [WIDTH-1:0]  b_neg;
    logic [WIDTH-1:0]  b_op;
    logic [WIDTH-1:0]  result;

    assign accept = (state == IDLE) && bus.start;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DRAIN ends once stage 1 is empty: the write in flight that cycle is
    // the last one, so the following cycle is the done cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = READ;
            READ:    if (rd_addr_q == LAST) state_nx = DRAIN;
            DRAIN:   if (!v1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read address counter and latched mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            sub_q     <= 1'b0;
        end else if (accept) begin
            rd_addr_q <= '0;
            sub_q     <= bus.sub;
        end else if ((state == READ) && (rd_addr_q != LAST)) begin
            rd_addr_q <= rd_addr_q + 1'b1;
        end
    end

    // Stage 1 tracking; data itself comes straight from the memories
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            addr1 <= '0;
        end else begin
            v1 <= (state == READ);
            if (state == READ) begin
                addr1 <= rd_addr_q;
            end
        end
    end

    // Subtraction as addition of the modular negative; b = 0 maps to 0
    // so the operand stays inside [0, Q).
    always_comb begin
        b_neg = (bus.rd_data_b == '0) ? '0 : QW - bus.rd_data_b;
        b_op  = sub_q ? b_neg : bus.rd_data_b;
    end

    mod_add #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_mod_add (
        .a (bus.rd_data_a),
        .b (b_op),
        .y (result)
    );

    // Stage 2: write port holds address/data while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= v1;
            if (v1) begin
                wr_addr_q <= addr1;
                wr_data_q <= result;
            end
        end
    end

    always_comb begin
        bus.busy    = (state == READ) || (state == DRAIN);
        bus.done    = (state == DONE);
        bus.rd_en   = (state == READ);
        bus.rd_addr = rd_addr_q;
        bus.wr_en   = wr_en_q;
        bus.wr_addr = wr_addr_q;
        bus.wr_data = wr_data_q;
    end
endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// tb_poly_addsub_ctrl
//   Directed bench for poly_addsub_ctrl: an N=8 instance for exact-timing
//   add/sub/abort/start-filtering checks and an N=256 instance for
//   random jobs against a reference model.
module tb_poly_addsub_ctrl;
    localparam int unsigned W  = 32;
    localparam int unsigned Q  = 8380417;
    localparam int unsigned NS = 8;
    localparam int unsigned AS = 3;
    localparam int unsigned NL = 256;
    localparam int unsigned AL = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    poly_addsub_ctrl_if #(.WIDTH(W), .ADDR_W(AS)) s_if ();
    poly_addsub_ctrl_if #(.WIDTH(W), .ADDR_W(AL)) l_if ();

    poly_addsub_ctrl #(.WIDTH(W), .Q(Q), .N(NS), .ADDR_W(AS)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    poly_addsub_ctrl #(.WIDTH(W), .Q(Q), .N(NL), .ADDR_W(AL)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (l_if.slave)
    );

    logic [W-1:0] sa [NS];
    logic [W-1:0] sb [NS];
    logic [W-1:0] exp_s [NS];
    logic [W-1:0] la [NL];
    logic [W-1:0] lb [NL];

    // synchronous-read memories
    always @(posedge clk) begin
        if (s_if.rd_en) begin
            s_if.rd_data_a <= sa[s_if.rd_addr];
            s_if.rd_data_b <= sb[s_if.rd_addr];
        end
        if (l_if.rd_en) begin
            l_if.rd_data_a <= la[l_if.rd_addr];
            l_if.rd_data_b <= lb[l_if.rd_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m);
        longint r;
        r = m ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
        if (r < 0) r = r + longint'(Q);
        if (r >= longint'(Q)) r = r - longint'(Q);
        return r[W-1:0];
    endfunction

    task automatic load_add();
        sa = '{0, 1, 8380416, 4190208, 100, 8380000, 7, 4190209};
        sb = '{0, 8380416, 8380416, 4190209, 200, 416, 8380409, 4190300};
    endtask

    // Call right after a negedge. Observes cycles T0+1 .. T0+NS+4, returns
    // at the negedge of T0+NS+4 (IDLE) so a following call starts there.
    task automatic job_s(input logic mode, input bit noisy);
        s_if.start = 1'b1;
        s_if.sub   = mode;
        for (int i = 1; i <= NS + 4; i++) begin
            @(negedge clk);
            s_if.start = 1'b0;
            s_if.sub   = mode;
            chk("s_rd_en", s_if.rd_en, (i <= NS));
            if (i <= NS) chk("s_rd_addr", s_if.rd_addr, i - 1);
            chk("s_wr_en", s_if.wr_en, (i >= 3 && i <= NS + 2));
            if (i >= 3 && i <= NS + 2) begin
                chk("s_wr_addr", s_if.wr_addr, i - 3);
                chk("s_wr_data", s_if.wr_data, exp_s[i-3]);
            end
            chk("s_busy", s_if.busy, (i <= NS + 2));
            chk("s_done", s_if.done, (i == NS + 3));
            if (i == NS + 4) begin
                chk("s_rd_addr_hold", s_if.rd_addr, NS - 1);
                chk("s_wr_addr_hold", s_if.wr_addr, NS - 1);
            end
            if (noisy && i <= NS + 3) begin
                s_if.start = (i % 2 == 1) || (i == NS + 3);
                s_if.sub   = (i % 3 == 0) ? mode : ~mode;
            end
        end
        s_if.start = 1'b0;
    endtask

    task automatic job_l(input logic mode);
        int cnt [NL];
        int nxt;
        for (int k = 0; k < NL; k++) begin
            la[k]  = $urandom_range(Q - 1, 0);
            lb[k]  = $urandom_range(Q - 1, 0);
            cnt[k] = 0;
        end
        la[0] = 0;     lb[0] = 0;
        la[1] = Q - 1; lb[1] = Q - 1;
        la[2] = 0;     lb[2] = Q - 1;
        la[3] = Q - 1; lb[3] = 0;
        nxt = 0;
        l_if.start = 1'b1;
        l_if.sub   = mode;
        for (int i = 1; i <= NL + 4; i++) begin
            @(negedge clk);
            l_if.start = 1'b0;
            l_if.sub   = 1'($urandom_range(1, 0));
            chk("l_wr_en", l_if.wr_en, (i >= 3 && i <= NL + 2));
            if (l_if.wr_en === 1'b1 && nxt < NL) begin
                chk("l_wr_addr", l_if.wr_addr, nxt);
                chk("l_wr_data", l_if.wr_data, model(la[nxt], lb[nxt], mode));
                cnt[l_if.wr_addr] = cnt[l_if.wr_addr] + 1;
                nxt++;
            end
            chk("l_done", l_if.done, (i == NL + 3));
        end
        chk("l_write_total", nxt, NL);
        for (int k = 0; k < NL; k++) chk("l_addr_once", cnt[k], 1);
        l_if.sub = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        s_if.start = 1'b1;
        s_if.sub   = 1'b1;
        l_if.start = 1'b1;
        l_if.sub   = 1'b0;

        // reset held with start high
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk("rst_busy", s_if.busy, 0);
            chk("rst_done", s_if.done, 0);
            chk("rst_rd_en", s_if.rd_en, 0);
            chk("rst_wr_en", s_if.wr_en, 0);
            chk("rst_rd_addr", s_if.rd_addr, 0);
            chk("rst_wr_addr", s_if.wr_addr, 0);
            chk("rst_wr_data", s_if.wr_data, 0);
            chk("rst_l_busy", l_if.busy, 0);
            chk("rst_l_rd_en", l_if.rd_en, 0);
        end
        s_if.start = 1'b0;
        l_if.start = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        chk("idle_busy", s_if.busy, 0);
        chk("idle_rd_en", s_if.rd_en, 0);

        // add mode
        load_add();
        exp_s = '{0, 0, 8380415, 0, 300, 8380416, 8380416, 92};
        job_s(1'b0, 1'b0);

        // add again with start/sub noise, then back-to-back sub job
        job_s(1'b0, 1'b1);
        exp_s = '{0, 2, 0, 8380416, 8380317, 8379584, 15, 8380326};
        job_s(1'b1, 1'b0);

        // sub mode
        sa    = '{5, 0, 0, 8380416, 100, 1, 8380416, 4190208};
        sb    = '{3, 1, 0, 8380416, 200, 8380416, 0, 1};
        exp_s = '{2, 8380416, 0, 0, 8380317, 2, 8380416, 4190207};
        job_s(1'b1, 1'b0);

        // abort: reset sampled at the end of T0+4
        load_add();
        exp_s = '{0, 0, 8380415, 0, 300, 8380416, 8380416, 92};
        s_if.start = 1'b1;
        s_if.sub   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            s_if.start = 1'b0;
            if (i >= 3) begin
                chk("ab_wr_en", s_if.wr_en, 1);
                chk("ab_wr_addr", s_if.wr_addr, i - 3);
            end
        end
        rst_n = 1'b0;
        for (int i = 5; i <= NS + 6; i++) begin
            @(negedge clk);
            chk("ab_no_wr", s_if.wr_en, 0);
            chk("ab_no_done", s_if.done, 0);
            if (i == 5) begin
                chk("ab_busy", s_if.busy, 0);
                chk("ab_rd_en", s_if.rd_en, 0);
                chk("ab_rd_addr", s_if.rd_addr, 0);
                chk("ab_wr_data", s_if.wr_data, 0);
            end
            rst_n = 1'b1;
        end
        job_s(1'b0, 1'b0);

        // random full-size jobs, add then sub
        job_l(1'b0);
        job_l(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
